// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit with an elastic valid/ready pipeline.
// Extension is combinational into stage 0; DEPTH register stages follow; bubbles collapse.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_imm,
  input  logic [2:0]                   in_op,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_imm,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned EXT_W = OUT_W - IN_W;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_imm;
  logic             ext_err;

  always_comb begin
    sext    = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext_imm = '0;
    ext_err = 1'b0;
    case (in_op)
      3'd0:    ext_imm = {{EXT_W{1'b0}}, in_imm};
      3'd1:    ext_imm = sext;
      3'd2:    ext_imm = {in_imm, {EXT_W{1'b0}}};
      3'd3:    ext_imm = sext << 2;
      default: ext_err = 1'b1;
    endcase
  end

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][OUT_W-1:0]  imm_q, imm_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [DEPTH-1:0]             err_q, err_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [DEPTH-1:0]             adv;
  logic                         blocked;

  // A stage is blocked only if every stage downstream of it is full and the sink stalls.
  always_comb begin
    blocked = 1'b0;
    adv     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      blocked = ~out_ready;
      for (int j = k + 1; j < DEPTH; j++) begin
        blocked = blocked & valid_q[j];
      end
      adv[k] = valid_q[k] & ~blocked;
    end
  end

  assign in_ready = ~flush & (~valid_q[0] | adv[0]);

  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    tag_d   = tag_q;
    err_d   = err_q;
    occ_d   = '0;

    if (in_valid && in_ready) begin
      valid_d[0] = 1'b1;
      imm_d[0]   = ext_imm;
      tag_d[0]   = in_tag;
      err_d[0]   = ext_err;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k-1] && !flush) begin
        valid_d[k] = 1'b1;
        imm_d[k]   = imm_q[k-1];
        tag_d[k]   = tag_q[k-1];
        err_d[k]   = err_q[k-1];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
      end
    end

    if (flush) begin
      valid_d = '0;
    end

    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      imm_q   <= '0;
      tag_q   <= '0;
      err_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_imm   = imm_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the pipelined MIPS datapath.
- Takes a raw instruction immediate plus extension opcode and tag; delivers the extended value DEPTH cycles later through a valid/ready elastic pipeline.
- Adds a branch-offset mode, illegal-op flagging, flush and occupancy reporting.
- Sits between decode and the operand-select stage.

Parameters:
IN_W, 16, raw immediate width
OUT_W, 32, extended result width; must satisfy OUT_W >= IN_W+2
DEPTH, 2, number of register stages; must be >= 1
TAG_W, 5, width of sideband tag carried alongside data (e.g. destination register)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
flush  input  1  drop all in-flight entries this cycle
in_valid  input  1  upstream holds a valid request
in_ready  output  1  unit accepts request this cycle
in_imm  input  IN_W  raw immediate
in_op  input  3  extension mode
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_imm  output  OUT_W  extended immediate
out_tag  output  TAG_W  tag of result
out_err  output  1  result came from an illegal op
occupancy  output  clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (reset_n): state changes only on a rising clk edge where reset_n=0.
- Extension is combinational on the input side, registered into stage 0.
  - op 0 ZERO: zero-extend in_imm.
  - op 1 SIGN: sign-extend from bit IN_W-1.
  - op 2 UPPER: in_imm placed in the top IN_W bits, low OUT_W-IN_W bits zero.
  - op 3 BRANCH: sign-extend, then shift left 2. Bits shifted out are discarded; the result stays OUT_W wide.
  - op 4-7: result 0, err=1.
  - err=0 for ops 0-3.
- Stages: stage k holds {valid, imm, tag, err}. Stage DEPTH-1 drives out_*.
- Advance rules:
  - Last stage advances when out_valid and out_ready.
  - Stage k advances into k+1 when stage k+1 is empty or stage k+1 is advancing.
  - A stage with an empty predecessor and no load clears its valid.
  - Bubbles collapse: a stalled downstream does not prevent earlier stages from filling empty slots.
- in_ready = !flush && (stage0 empty || stage0 advancing). A transfer occurs when in_valid && in_ready.
- Latency: an accepted request reaches out_valid DEPTH cycles after acceptance when out_ready stays 1. Throughput is 1 per cycle sustained.
- Stall: while out_ready=0, out_imm/out_tag/out_err stay stable and out_valid stays high. Data never changes under a held valid.
- Full: when all DEPTH stages are valid and out_ready=0, in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle (pass-through of the ready chain, no bubble).
- Flush:
  - Flush=1 clears every stage valid at the clock edge.
  - No input is accepted in that cycle (in_ready=0).
  - Flush and a downstream handshake in the same cycle: the downstream handshake still counts as consumed.
  - Flush has priority over every load.
- Reset (reset_n=0 at edge):
  - All valids cleared; all data registers set to 0.
  - Outputs after reset: out_valid=0, out_imm=0, out_tag=0, out_err=0, occupancy=0, in_ready=1 (once reset_n=1 and flush=0).
  - Reset mid-stream discards in-flight entries without emitting them.
- Data registers of invalid stages hold their last value. Benches must check out_imm only when out_valid=1.
- occupancy = count of valid stages, registered. Range 0..DEPTH.

Test Plan:
- Modes (defaults), out_ready=1, one request per cycle, ops 0..3 on in_imm=16'h8001. Expect results two cycles later, err=0:
  - op 0 -> 32'h00008001
  - op 1 -> 32'hFFFF8001
  - op 2 -> 32'h80010000
  - op 3 -> 32'hFFFE0004
- Illegal op: op=5, imm=16'h1234, tag=7 -> out_imm=0, out_err=1, out_tag=7.
- Backpressure: 3 requests (tags 1,2,3) with out_ready=0.
  - Expect occupancy=2 and in_ready=0 after 2 accepts; tag1 held stable on the outputs.
  - Raise out_ready: expect tags 1,2,3 in order, no loss or duplication.
  - Confirm in_ready=1 on the cycle the full pipe drains.
- Flush: 2 in flight, flush=1 with in_valid=1 -> in_ready=0 that cycle. Next cycle: occupancy=0, out_valid=0. The flush-cycle request is not accepted.
- Reset mid-stream: reset_n=0 for 1 cycle with 2 entries in flight -> out_valid=0, out_imm=0, occupancy=0, in_ready=1 afterwards.
- Parameter sweep: DEPTH=1 and DEPTH=4, IN_W=8/OUT_W=16, op 1 on imm=8'h80 -> 16'hFF80, latency equals DEPTH.
